// File: rtl/lcd_bus_if.sv
// Requester-side handshake bundle for the shared LCD bus arbiter.
// The sequencers (master) raise a request with rs/data; the arbiter (slave) answers with ack/err.
interface lcd_bus_if;
    logic       req0;
    logic       rs0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic       rs1;
    logic [7:0] data1;
    logic       ack1;
    logic       err;
    logic       busy;

    modport master (
        output req0, rs0, data0, req1, rs1, data1,
        input  ack0, ack1, err, busy
    );

    modport slave (
        input  req0, rs0, data0, req1, rs1, data1,
        output ack0, ack1, err, busy
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin owner of an HD44780-style 8-bit LCD bus: polls BF, then performs one timed write.
// All pin-facing outputs are registered and change together with the state.
module lcd_bus_arbiter #(
    parameter int SETUP_CYC  = 3,
    parameter int EN_CYC     = 25,
    parameter int HOLD_CYC   = 25,
    parameter int POLL_LIMIT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    lcd_bus_if.slave   bus,
    output logic       rs_lcd,
    output logic       rw_lcd,
    output logic       en_lcd,
    output logic       on_lcd,
    inout  wire  [7:0] data_lcd
);

    typedef enum logic [2:0] {
        IDLE, P_SETUP, P_EN, P_HOLD, W_SETUP, W_EN, W_HOLD, DONE
    } state_t;

    // Phase counters are loaded with length-1 and count down to zero.
    localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EN_LD     = 16'(EN_CYC - 1);
    localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYC - 1);
    localparam logic [11:0] POLL_LAST = 12'(POLL_LIMIT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [11:0] poll_cnt;
    logic        last;
    logic        gnt;
    logic        pick;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        bf_q;
    logic        drive;

    // The requester not granted last wins a tie; a lone requester wins outright.
    always_comb begin
        pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
    end

    assign data_lcd = drive ? data_q : 8'bz;

    // NOTE: every register here is assigned with <= so all state and outputs
    // update from the same pre-edge values; mixing in = would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            poll_cnt  <= '0;
            last      <= 1'b1;
            gnt       <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= '0;
            bf_q      <= 1'b0;
            drive     <= 1'b0;
            rs_lcd    <= 1'b0;
            rw_lcd    <= 1'b0;
            en_lcd    <= 1'b0;
            on_lcd    <= 1'b0;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each is high for exactly one cycle.
            on_lcd   <= 1'b1;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt      <= pick;
                        rs_q     <= pick ? bus.rs1 : bus.rs0;
                        data_q   <= pick ? bus.data1 : bus.data0;
                        cnt      <= SETUP_LD;
                        rs_lcd   <= 1'b0;
                        rw_lcd   <= 1'b1;
                        bus.busy <= 1'b1;
                        state    <= P_SETUP;
                    end
                end
                P_SETUP: begin
                    if (cnt == 16'd0) begin
                        cnt    <= EN_LD;
                        en_lcd <= 1'b1;
                        state  <= P_EN;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                P_EN: begin
                    if (cnt == 16'd0) begin
                        bf_q   <= data_lcd[7];
                        cnt    <= HOLD_LD;
                        en_lcd <= 1'b0;
                        state  <= P_HOLD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                P_HOLD: begin
                    if (cnt == 16'd0) begin
                        if (!bf_q) begin
                            cnt    <= SETUP_LD;
                            rs_lcd <= rs_q;
                            rw_lcd <= 1'b0;
                            drive  <= 1'b1;
                            state  <= W_SETUP;
                        end else if (poll_cnt == POLL_LAST) begin
                            rw_lcd   <= 1'b0;
                            bus.err  <= 1'b1;
                            bus.ack0 <= ~gnt;
                            bus.ack1 <= gnt;
                            state    <= DONE;
                        end else begin
                            poll_cnt <= poll_cnt + 12'd1;
                            cnt      <= SETUP_LD;
                            state    <= P_SETUP;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                W_SETUP: begin
                    if (cnt == 16'd0) begin
                        cnt    <= EN_LD;
                        en_lcd <= 1'b1;
                        state  <= W_EN;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                W_EN: begin
                    if (cnt == 16'd0) begin
                        cnt    <= HOLD_LD;
                        en_lcd <= 1'b0;
                        state  <= W_HOLD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                W_HOLD: begin
                    if (cnt == 16'd0) begin
                        rs_lcd   <= 1'b0;
                        drive    <= 1'b0;
                        bus.ack0 <= ~gnt;
                        bus.ack1 <= gnt;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE: begin
                    last     <= gnt;
                    poll_cnt <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: LCD model answers BF polls and logs write strobes;
// directed table, multi-cycle corner sequences and randomized rounds against a transaction model.
module tb_lcd_bus_arbiter;

    localparam int S  = 2;
    localparam int E  = 3;
    localparam int H  = 2;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rs_lcd, rw_lcd, en_lcd, on_lcd;
    wire  [7:0] data_lcd;

    lcd_bus_if bus();

    lcd_bus_arbiter #(.SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .POLL_LIMIT(PL)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rs_lcd   (rs_lcd),
        .rw_lcd   (rw_lcd),
        .en_lcd   (en_lcd),
        .on_lcd   (on_lcd),
        .data_lcd (data_lcd)
    );

    always #5 clk = ~clk;

    // LCD model: reports BF=1 while bf_cnt>0, one count consumed per read strobe.
    int         bf_cnt = 0;
    int         reads  = 0;
    logic [8:0] wq[$];
    int         viol   = 0;

    assign data_lcd = rw_lcd ? {bf_cnt > 0, 7'h00} : 8'bz;

    always @(negedge en_lcd) begin
        if (rst) begin
            if (rw_lcd) begin
                reads++;
                if (bf_cnt > 0) bf_cnt--;
            end else begin
                wq.push_back({rs_lcd, data_lcd});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.ack0 && bus.ack1) viol++;
            if (en_lcd && !bus.busy) viol++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         r0, r1, rs0, rs1;
        logic [7:0] d0, d1;
        int         k;
        int         n_acks;
        bit         id0, id1, er0, er1;
        int         rd;
        int         n_wr;
        logic [8:0] w0, w1;
    } vec_t;

    function automatic vec_t mk(bit r0, bit rs0, logic [7:0] d0, bit r1, bit rs1, logic [7:0] d1,
                                int k, int n_acks, bit id0, bit er0, bit id1, bit er1,
                                int rd, int n_wr, logic [8:0] w0, logic [8:0] w1);
        vec_t v;
        v.r0 = r0; v.rs0 = rs0; v.d0 = d0; v.r1 = r1; v.rs1 = rs1; v.d1 = d1; v.k = k;
        v.n_acks = n_acks; v.id0 = id0; v.er0 = er0; v.id1 = id1; v.er1 = er1;
        v.rd = rd; v.n_wr = n_wr; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    // Transaction-level model: order from round-robin, each transaction eats BF polls up to PL.
    function automatic void predict(input vec_t v, input bit last_in, output vec_t e, output bit last_out);
        bit ids[2];
        int n;
        int k;
        e = v;
        e.n_acks = 0; e.rd = 0; e.n_wr = 0;
        e.id0 = 0; e.id1 = 0; e.er0 = 0; e.er1 = 0; e.w0 = '0; e.w1 = '0;
        k = v.k;
        if (v.r0 && v.r1) begin
            ids[0] = ~last_in; ids[1] = last_in; n = 2;
        end else begin
            ids[0] = v.r1; ids[1] = 1'b0; n = 1;
        end
        last_out = last_in;
        for (int i = 0; i < n; i++) begin
            bit failed = (k >= PL);
            logic [8:0] w = ids[i] ? {v.rs1, v.d1} : {v.rs0, v.d0};
            if (failed) begin
                e.rd += PL;
                k    -= PL;
            end else begin
                e.rd += k + 1;
                k     = 0;
                if (e.n_wr == 0) e.w0 = w; else e.w1 = w;
                e.n_wr++;
            end
            if (i == 0) begin e.id0 = ids[i]; e.er0 = failed; end
            else        begin e.id1 = ids[i]; e.er1 = failed; end
            e.n_acks++;
            last_out = ids[i];
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bf_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Applies one round from idle; drops each requester's req on its ack.
    task automatic apply(input vec_t v, input string tag);
        logic [1:0] ids;
        logic [1:0] errs;
        int got = 0;
        ids = '0; errs = '0;
        bf_cnt = v.k; reads = 0; wq.delete();
        bus.req0 = v.r0; bus.rs0 = v.rs0; bus.data0 = v.d0;
        bus.req1 = v.r1; bus.rs1 = v.rs1; bus.data1 = v.d1;
        for (int c = 0; c < 2000 && got < v.n_acks; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                ids[got]  = bus.ack1;
                errs[got] = bus.err;
                if (bus.ack0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
                got++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        check({tag, " acks"}, got, v.n_acks);
        check({tag, " id0"}, ids[0], v.id0);
        check({tag, " err0"}, errs[0], v.er0);
        if (v.n_acks > 1) begin
            check({tag, " id1"}, ids[1], v.id1);
            check({tag, " err1"}, errs[1], v.er1);
        end
        check({tag, " reads"}, reads, v.rd);
        check({tag, " writes"}, wq.size(), v.n_wr);
        if (v.n_wr > 0 && wq.size() > 0) check({tag, " wr0"}, wq[0], v.w0);
        if (v.n_wr > 1 && wq.size() > 1) check({tag, " wr1"}, wq[1], v.w1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t v, e;
        bit   mdl_last;
        int   n;
        int   ord[4];
        int   got;
        bit   seen;

        bus.req0 = 0; bus.rs0 = 0; bus.data0 = 0;
        bus.req1 = 0; bus.rs1 = 0; bus.data1 = 0;

        tbl[0] = mk(1, 0, 8'h38, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 1, 9'h038, 9'h000);
        tbl[1] = mk(0, 0, 8'h00, 1, 1, 8'h50, 2, 1, 1, 0, 0, 0, 3, 1, 9'h150, 9'h000);
        tbl[2] = mk(1, 0, 8'h01, 0, 0, 8'h00, 4, 1, 0, 1, 0, 0, 4, 0, 9'h000, 9'h000);
        tbl[3] = mk(1, 1, 8'h11, 1, 0, 8'h22, 0, 2, 1, 0, 0, 0, 2, 2, 9'h022, 9'h111);
        tbl[4] = mk(1, 0, 8'hAA, 1, 1, 8'hBB, 5, 2, 1, 1, 0, 0, 6, 1, 9'h0AA, 9'h000);

        // Reset state and power-on.
        repeat (2) @(negedge clk);
        check("rst rs_lcd", rs_lcd, 0);
        check("rst rw_lcd", rw_lcd, 0);
        check("rst en_lcd", en_lcd, 0);
        check("rst on_lcd", on_lcd, 0);
        check("rst acks/err/busy", {bus.ack0, bus.ack1, bus.err, bus.busy}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("on_lcd after reset", on_lcd, 1);
        check("idle busy", bus.busy, 0);

        for (int i = 0; i < 5; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back contention: order 0,1,0,1.
        do_reset();
        reads = 0; wq.delete();
        bus.req0 = 1; bus.rs0 = 0; bus.data0 = 8'h01;
        bus.req1 = 1; bus.rs1 = 1; bus.data1 = 8'h41;
        got = 0;
        for (int c = 0; c < 400 && got < 4; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                ord[got] = bus.ack1 ? 1 : 0;
                got++;
                if (got == 4) begin bus.req0 = 0; bus.req1 = 0; end
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk);
        check("b2b acks", got, 4);
        for (int i = 0; i < 4 && i < got; i++) check($sformatf("b2b order%0d", i), ord[i], i % 2);
        check("b2b writes", wq.size(), 4);

        // Latency and phase timing with BF=0.
        do_reset();
        reads = 0; wq.delete(); bf_cnt = 0;
        bus.req0 = 1; bus.rs0 = 0; bus.data0 = 8'h38;
        @(posedge clk);
        n = 0; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            n++;
            if (n == 3) check("poll strobe en/rw", {en_lcd, rw_lcd}, 2'b11);
            if (n == 8) check("write setup rw/rs/data", {rw_lcd, rs_lcd, data_lcd}, {2'b00, 8'h38});
            if (bus.ack0) begin seen = 1; bus.req0 = 0; end
        end
        @(negedge clk);
        check("latency cycles", n, 2 * (S + E + H) + 1);
        check("latency reads", reads, 1);
        check("latency write", (wq.size() == 1) ? wq[0] : 9'h1FF, 9'h038);

        // Data changed after grant: latched copy goes out.
        reads = 0; wq.delete();
        bus.req0 = 1; bus.data0 = 8'h0C;
        repeat (3) @(negedge clk);
        bus.data0 = 8'hFF;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.ack0) begin seen = 1; bus.req0 = 0; end
        end
        @(negedge clk);
        check("latched data ack", seen, 1);
        check("latched data", (wq.size() == 1) ? wq[0] : 9'h1FF, 9'h00C);

        // Reset asserted during the write strobe.
        wq.delete();
        bus.req0 = 1; bus.data0 = 8'h5A;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (en_lcd && !rw_lcd) seen = 1;
        end
        check("reached write strobe", seen, 1);
        rst = 1'b0;
        #1;
        check("mid-reset en/on/rw/busy", {en_lcd, on_lcd, rw_lcd, bus.busy}, 4'b0000);
        bus.req0 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) got++;
        end
        check("no ack after reset", got, 0);
        check("no write after reset", wq.size(), 0);

        // Randomized rounds against the transaction model.
        do_reset();
        mdl_last = 1'b1;
        for (int r = 0; r < 25; r++) begin
            v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   int'($urandom_range(0, 9)), 0, 0, 0, 0, 0, 0, 0, 9'h0, 9'h0);
            if (!v.r0 && !v.r1) v.r0 = 1'b1;
            predict(v, mdl_last, e, mdl_last);
            apply(e, $sformatf("rnd%0d", r));
        end

        check("protocol violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
